// File: rtl/barrel_shift_8bit.sv
// Registered logical barrel shifter: log2(WIDTH) cascaded mux stages
// (shift by 1, 2, 4, ...), zero fill, one-cycle latency.

module bs_stage #(
  parameter int WIDTH = 8,
  parameter int SHAMT = 1
) (
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_en,
  input  logic             i_left,
  output logic [WIDTH-1:0] o_d
);
  logic [WIDTH-1:0] w_lft, w_rgt;

  // Constant-index wiring only; the variable amount lives in the stage enables.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    if (b >= SHAMT) begin : g_lsrc
      assign w_lft[b] = i_d[b-SHAMT];
    end else begin : g_lzero
      assign w_lft[b] = 1'b0;
    end
    if (b + SHAMT < WIDTH) begin : g_rsrc
      assign w_rgt[b] = i_d[b+SHAMT];
    end else begin : g_rzero
      assign w_rgt[b] = 1'b0;
    end
  end

  assign o_d = !i_en  ? i_d   :
               i_left ? w_lft : w_rgt;
endmodule

module barrel_shift_8bit #(
  parameter int WIDTH = 8,
  localparam int SW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             Lr,
  input  logic [SW-1:0]    n,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);
  logic [SW:0][WIDTH-1:0] w_stg;
  logic [WIDTH-1:0]       r_out;
  logic                   r_vld;

  assign w_stg[0] = in;

  for (genvar s = 0; s < SW; s++) begin : g_stage
    bs_stage #(.WIDTH(WIDTH), .SHAMT(1 << s)) u_stage (
      .i_d    (w_stg[s]),
      .i_en   (n[s]),
      .i_left (Lr),
      .o_d    (w_stg[s+1])
    );
  end

  // Result holds when idle; only the valid flag drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= in_valid;
      if (in_valid) r_out <= w_stg[SW];
    end
  end

  assign out       = r_out;
  assign out_valid = r_vld;
endmodule

// File: tb/tb_barrel_shift_8bit.sv
// Self-checking bench: directed cases, exhaustive sweep and random traffic
// against an arithmetic shift model.

module tb_barrel_shift_8bit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d_in = '0;
  logic       d_lr = 1'b0;
  logic [2:0] d_n  = '0;
  logic       d_vld = 1'b0;
  logic [7:0] q_out;
  logic       q_vld;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_out = '0;
  logic       exp_vld = 1'b0;

  barrel_shift_8bit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (d_in),
    .Lr        (d_lr),
    .n         (d_n),
    .in_valid  (d_vld),
    .out       (q_out),
    .out_valid (q_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Logical shift via multiply/divide by a power of two.
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic lr, input int sh);
    int p = 1 << sh;
    int v = int'(d);
    if (lr) return 8'((v * p) % 256);
    else    return 8'(v / p);
  endfunction

  task automatic step(input logic vld, input logic [7:0] d, input logic lr,
                      input logic [2:0] sh, input string tag);
    @(negedge clk);
    d_vld = vld; d_in = d; d_lr = lr; d_n = sh;
    @(posedge clk);
    #1;
    if (vld) exp_out = ref_shift(d, lr, int'(sh));
    exp_vld = vld;
    chk({tag, "_out"}, 32'(q_out), 32'(exp_out));
    chk({tag, "_vld"}, 32'(q_vld), 32'(exp_vld));
  endtask

  task automatic req_const(input logic [7:0] d, input logic lr, input logic [2:0] sh,
                           input logic [7:0] want, input string tag);
    step(1'b1, d, lr, sh, tag);
    chk({tag, "_const"}, 32'(q_out), 32'(want));
  endtask

  initial begin
    // Reset state while held low
    #2;
    chk("rst_out", 32'(q_out), 32'h0);
    chk("rst_vld", 32'(q_vld), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_out", 32'(q_out), 32'h0);

    // Directed values
    req_const(8'hB7, 1'b1, 3'd3, 8'hB8, "l3");
    req_const(8'hB7, 1'b1, 3'd4, 8'h70, "l4");
    req_const(8'hB7, 1'b0, 3'd2, 8'h2D, "r2");
    req_const(8'hB7, 1'b0, 3'd3, 8'h16, "r3");
    req_const(8'hB7, 1'b1, 3'd0, 8'hB7, "l0");
    req_const(8'hB7, 1'b0, 3'd0, 8'hB7, "r0");
    req_const(8'hB7, 1'b1, 3'd7, 8'h80, "l7");
    req_const(8'hB7, 1'b0, 3'd7, 8'h01, "r7");
    req_const(8'hFF, 1'b1, 3'd7, 8'h80, "ff_l7");

    // Back-to-back alternating direction/amount, then idle hold
    for (int i = 0; i < 8; i++)
      step(1'b1, 8'h5A + 8'(i * 17), 1'(i & 1), 3'(i), "b2b");
    step(1'b0, 8'hFF, 1'b1, 3'd1, "hold1");
    step(1'b0, 8'h00, 1'b0, 3'd5, "hold2");

    // Asynchronous reset mid-cycle with a result pending
    step(1'b1, 8'hF0, 1'b0, 3'd1, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out", 32'(q_out), 32'h0);
    chk("async_vld", 32'(q_vld), 32'h0);
    exp_out = '0; exp_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h81, 1'b1, 3'd1, "post_rst");

    // Exhaustive sweep
    for (int lr = 0; lr < 2; lr++)
      for (int sh = 0; sh < 8; sh++)
        for (int d = 0; d < 256; d++)
          step(1'b1, 8'(d), 1'(lr), 3'(sh), "exh");

    // Random traffic with idle gaps
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
           3'($urandom_range(0, 7)), "rnd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
